// File: rtl/imem_loader.sv
// Loads a host word stream into the single-port I-SRAM and holds the core in reset until the image is committed.
// Optional read-back checksum verification is enabled with the IMEM_CHECKSUM_EN macro.
module imem_loader #(
  parameter int DEPTH  = 816,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start_i,
  input  logic [ADDR_W-1:0] load_base_i,
  input  logic [LEN_W-1:0]  load_len_i,
  input  logic [31:0]       wdata_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  output logic              sram_ceb_o,
  output logic              sram_web_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [31:0]       sram_d_o,
  input  logic [31:0]       sram_q_i,
  output logic              core_resetn_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [LEN_W-1:0]  words_loaded_o
`ifdef IMEM_CHECKSUM_EN
  ,
  input  logic [31:0]       checksum_i
`endif
);

`ifdef IMEM_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, VERIFY, DONE, ERROR} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, DONE, ERROR} state_t;
`endif

  state_t            state_q, state_d;
  logic              wready_q, wready_d;
  logic              ceb_q, ceb_d;
  logic              web_q, web_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              core_resetn_q, core_resetn_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;

`ifdef IMEM_CHECKSUM_EN
  logic [LEN_W-1:0]  vcnt_q, vcnt_d;
  logic [31:0]       sum_q, sum_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       chk_q, chk_d;
  logic [31:0]       sum_next;
  assign sum_next = sum_q + sram_q_i;
`else
  logic unused_sram_q;
  assign unused_sram_q = ^sram_q_i;
`endif

  // End address is formed one bit wider than the length so base+len cannot overflow.
  logic [LEN_W:0] end_addr;
  logic           start_bad;
  assign end_addr  = {{(LEN_W+1-ADDR_W){1'b0}}, load_base_i} + {1'b0, load_len_i};
  assign start_bad = (load_len_i == '0) || (end_addr > (LEN_W+1)'(DEPTH));

  always_comb begin
    state_d       = state_q;
    wready_d      = wready_q;
    ceb_d         = 1'b1;
    web_d         = 1'b1;
    addr_d        = addr_q;
    data_d        = data_q;
    core_resetn_d = core_resetn_q;
    busy_d        = busy_q;
    done_d        = done_q;
    error_d       = error_q;
    cnt_d         = cnt_q;
    base_d        = base_q;
    len_d         = len_q;
`ifdef IMEM_CHECKSUM_EN
    vcnt_d        = vcnt_q;
    sum_d         = sum_q;
    rvalid_d      = 1'b0;
    chk_d         = chk_q;
`endif

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (load_start_i) begin
          core_resetn_d = 1'b0;
          done_d        = 1'b0;
          if (start_bad) begin
            state_d  = ERROR;
            error_d  = 1'b1;
            busy_d   = 1'b0;
            wready_d = 1'b0;
          end else begin
            state_d  = LOAD;
            error_d  = 1'b0;
            busy_d   = 1'b1;
            wready_d = 1'b1;
            cnt_d    = '0;
            base_d   = load_base_i;
            len_d    = load_len_i;
`ifdef IMEM_CHECKSUM_EN
            chk_d    = checksum_i;
`endif
          end
        end
      end

      LOAD: begin
        if (wvalid_i && wready_q) begin
          ceb_d  = 1'b0;
          web_d  = 1'b0;
          addr_d = base_q + cnt_q[ADDR_W-1:0];
          data_d = wdata_i;
          cnt_d  = cnt_q + LEN_W'(1);
          if (cnt_q + LEN_W'(1) == len_q) begin
            wready_d = 1'b0;
            state_d  = FLUSH;
          end
        end
      end

      FLUSH: begin
`ifdef IMEM_CHECKSUM_EN
        state_d = VERIFY;
        ceb_d   = 1'b0;
        addr_d  = base_q;
        vcnt_d  = LEN_W'(1);
        sum_d   = '0;
`else
        state_d       = DONE;
        busy_d        = 1'b0;
        done_d        = 1'b1;
        core_resetn_d = 1'b1;
`endif
      end

`ifdef IMEM_CHECKSUM_EN
      VERIFY: begin
        // A read presented this cycle returns data next cycle.
        rvalid_d = !ceb_q;
        if (rvalid_q) begin
          sum_d = sum_next;
        end
        if (vcnt_q < len_q) begin
          ceb_d  = 1'b0;
          addr_d = base_q + vcnt_q[ADDR_W-1:0];
          vcnt_d = vcnt_q + LEN_W'(1);
        end else if (ceb_q && rvalid_q) begin
          busy_d = 1'b0;
          if (sum_next == chk_q) begin
            state_d       = DONE;
            done_d        = 1'b1;
            core_resetn_d = 1'b1;
          end else begin
            state_d = ERROR;
            error_d = 1'b1;
          end
        end
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      wready_q      <= 1'b0;
      ceb_q         <= 1'b1;
      web_q         <= 1'b1;
      addr_q        <= '0;
      data_q        <= '0;
      core_resetn_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      cnt_q         <= '0;
      base_q        <= '0;
      len_q         <= '0;
`ifdef IMEM_CHECKSUM_EN
      vcnt_q        <= '0;
      sum_q         <= '0;
      rvalid_q      <= 1'b0;
      chk_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      wready_q      <= wready_d;
      ceb_q         <= ceb_d;
      web_q         <= web_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      core_resetn_q <= core_resetn_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
      cnt_q         <= cnt_d;
      base_q        <= base_d;
      len_q         <= len_d;
`ifdef IMEM_CHECKSUM_EN
      vcnt_q        <= vcnt_d;
      sum_q         <= sum_d;
      rvalid_q      <= rvalid_d;
      chk_q         <= chk_d;
`endif
    end
  end

  assign wready_o       = wready_q;
  assign sram_ceb_o     = ceb_q;
  assign sram_web_o     = web_q;
  assign sram_addr_o    = addr_q;
  assign sram_d_o       = data_q;
  assign core_resetn_o  = core_resetn_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign error_o        = error_q;
  assign words_loaded_o = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a behavioural single-port SRAM attached to the write/read port.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        reset;
  logic        load_start_i;
  logic [9:0]  load_base_i;
  logic [10:0] load_len_i;
  logic [31:0] wdata_i;
  logic        wvalid_i;
  logic        wready_o;
  logic        sram_ceb_o, sram_web_o;
  logic [9:0]  sram_addr_o;
  logic [31:0] sram_d_o;
  logic [31:0] sram_q_i;
  logic        core_resetn_o, busy_o, done_o, error_o;
  logic [10:0] words_loaded_o;
`ifdef IMEM_CHECKSUM_EN
  logic [31:0] checksum_i = '0;
`endif

  int checks = 0;
  int failures = 0;
  logic [31:0] mem [0:815];
  logic [31:0] words [0:3];
  logic [4:0]  pat;

  always #5 clk = ~clk;

  imem_loader dut (
    .clk(clk), .reset(reset), .load_start_i(load_start_i), .load_base_i(load_base_i),
    .load_len_i(load_len_i), .wdata_i(wdata_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
    .sram_ceb_o(sram_ceb_o), .sram_web_o(sram_web_o), .sram_addr_o(sram_addr_o),
    .sram_d_o(sram_d_o), .sram_q_i(sram_q_i), .core_resetn_o(core_resetn_o),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .words_loaded_o(words_loaded_o)
`ifdef IMEM_CHECKSUM_EN
    , .checksum_i(checksum_i)
`endif
  );

  // Behavioural SRAM: synchronous write, 1-cycle registered read.
  always @(posedge clk) begin
    if (!sram_ceb_o) begin
      if (!sram_web_o) mem[sram_addr_o] <= sram_d_o;
      else             sram_q_i <= mem[sram_addr_o];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [9:0] base, input logic [10:0] len);
    load_start_i = 1'b1; load_base_i = base; load_len_i = len;
    tick();
    load_start_i = 1'b0;
  endtask

  initial begin
    words[0] = 32'h00000013; words[1] = 32'h00100093;
    words[2] = 32'h00200113; words[3] = 32'h00000073;
    reset = 1'b1; load_start_i = 1'b0; load_base_i = '0; load_len_i = '0;
    wdata_i = '0; wvalid_i = 1'b0;

    // Reset held for two cycles
    tick(); tick();
    check("rst_wready", 32'(wready_o), 32'd0);
    check("rst_ceb", 32'(sram_ceb_o), 32'd1);
    check("rst_web", 32'(sram_web_o), 32'd1);
    check("rst_addr", 32'(sram_addr_o), 32'd0);
    check("rst_d", sram_d_o, 32'd0);
    check("rst_coren", 32'(core_resetn_o), 32'd0);
    check("rst_flags", {29'd0, busy_o, done_o, error_o}, 32'd0);
    check("rst_words", 32'(words_loaded_o), 32'd0);
    reset = 1'b0;
    tick();
    check("idle_coren", 32'(core_resetn_o), 32'd0);

    // Back-to-back load of four words at base 0
    start(10'd0, 11'd4);
    check("t1_busy", 32'(busy_o), 32'd1);
    check("t1_wready", 32'(wready_o), 32'd1);
    check("t1_ceb_idle", 32'(sram_ceb_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      wvalid_i = 1'b1; wdata_i = words[i];
      tick();
      check($sformatf("t1_we%0d", i), {30'd0, sram_ceb_o, sram_web_o}, 32'd0);
      check($sformatf("t1_addr%0d", i), 32'(sram_addr_o), 32'(i));
      check($sformatf("t1_d%0d", i), sram_d_o, words[i]);
      check($sformatf("t1_cnt%0d", i), 32'(words_loaded_o), 32'(i + 1));
      check($sformatf("t1_coren%0d", i), 32'(core_resetn_o), 32'd0);
    end
    wvalid_i = 1'b0;
    check("t1_flush_wready", 32'(wready_o), 32'd0);
    tick();
    check("t1_done", 32'(done_o), 32'd1);
    check("t1_busy_off", 32'(busy_o), 32'd0);
    check("t1_coren", 32'(core_resetn_o), 32'd1);
    check("t1_ceb_done", 32'(sram_ceb_o), 32'd1);
    check("t1_words", 32'(words_loaded_o), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("t1_mem%0d", i), mem[i], words[i]);

    // Gappy stream: valid 1,0,1,0,1 at base 10
    start(10'd10, 11'd3);
    check("t2_coren_held", 32'(core_resetn_o), 32'd0);
    check("t2_done_clr", 32'(done_o), 32'd0);
    check("t2_cnt_clr", 32'(words_loaded_o), 32'd0);
    pat = 5'b10101;
    for (int i = 0; i < 5; i++) begin
      wvalid_i = pat[4-i]; wdata_i = 32'hA000_0000 + 32'(i);
      tick();
      check($sformatf("t2_ceb%0d", i), 32'(sram_ceb_o), 32'(!pat[4-i]));
      if (pat[4-i]) check($sformatf("t2_addr%0d", i), 32'(sram_addr_o), 32'(10 + i / 2));
    end
    wvalid_i = 1'b0;
    tick();
    check("t2_done", 32'(done_o), 32'd1);
    check("t2_words", 32'(words_loaded_o), 32'd3);
    check("t2_mem12", mem[12], 32'hA000_0004);

    // Out-of-range start, then a minimal valid load
    start(10'd810, 11'd7);
    check("t3_error", 32'(error_o), 32'd1);
    check("t3_done", 32'(done_o), 32'd0);
    check("t3_busy", 32'(busy_o), 32'd0);
    check("t3_ceb", 32'(sram_ceb_o), 32'd1);
    check("t3_wready", 32'(wready_o), 32'd0);
    check("t3_coren", 32'(core_resetn_o), 32'd0);
    tick();
    check("t3_ceb2", 32'(sram_ceb_o), 32'd1);
    start(10'd0, 11'd0);
    check("t3_len0_err", {30'd0, error_o, busy_o}, 32'd2);
    start(10'd812, 11'd4);
    check("t3_edge_ok", {30'd0, error_o, busy_o}, 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    start(10'd0, 11'd1);
    check("t3_err_clr", 32'(error_o), 32'd0);
    wvalid_i = 1'b1; wdata_i = 32'h1234_5678;
    tick();
    wvalid_i = 1'b0;
    check("t3_w_addr", 32'(sram_addr_o), 32'd0);
    check("t3_w_ceb", 32'(sram_ceb_o), 32'd0);
    tick();
    check("t3_done2", {29'd0, done_o, error_o, core_resetn_o}, 32'd5);

    // Second start ignored during LOAD, then reset mid-load
    start(10'd20, 11'd5);
    load_start_i = 1'b1; load_base_i = 10'd0; load_len_i = 11'd1;
    wvalid_i = 1'b1; wdata_i = 32'hBEEF_0000;
    tick();
    load_start_i = 1'b0;
    check("t4_addr0", 32'(sram_addr_o), 32'd20);
    wdata_i = 32'hBEEF_0001;
    tick();
    wvalid_i = 1'b0;
    check("t4_addr1", 32'(sram_addr_o), 32'd21);
    check("t4_cnt", 32'(words_loaded_o), 32'd2);
    check("t4_busy", 32'(busy_o), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t4_wready", 32'(wready_o), 32'd0);
    check("t4_coren", 32'(core_resetn_o), 32'd0);
    check("t4_busy_off", 32'(busy_o), 32'd0);
    check("t4_ceb", 32'(sram_ceb_o), 32'd1);
    check("t4_mem21", mem[21], 32'hBEEF_0001);

`ifdef IMEM_CHECKSUM_EN
    // Checksum verify: pass with sum 6, fail with 7
    for (int pass = 0; pass < 2; pass++) begin
      checksum_i = (pass == 0) ? 32'd6 : 32'd7;
      start(10'd0, 11'd3);
      for (int i = 1; i <= 3; i++) begin
        wvalid_i = 1'b1; wdata_i = 32'(i);
        tick();
      end
      wvalid_i = 1'b0;
      for (int n = 0; n < 20 && !(done_o || error_o); n++) tick();
      check($sformatf("cs%0d_done", pass), 32'(done_o), (pass == 0) ? 32'd1 : 32'd0);
      check($sformatf("cs%0d_err", pass), 32'(error_o), (pass == 0) ? 32'd0 : 32'd1);
      check($sformatf("cs%0d_coren", pass), 32'(core_resetn_o), (pass == 0) ? 32'd1 : 32'd0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
